// File: rtl/mult_accumulator.sv
// mult_accumulator: frames up to LEN products into a saturating sum with a registered valid/ready result
module mult_accumulator #(
    parameter int LEN   = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [17:0]      in_product,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [8:0]       out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [8:0]       cnt;
    logic             ovf;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_n;
    logic             ovf_n;
    logic             close;

    // in_ready is held low while rst is asserted so no beat is claimed during reset
    assign in_ready  = state == ACCUM && !rst;
    assign out_valid = state == HOLD;

    // next accumulator value: carry-out latches overflow and pins the sum at all-ones
    always_comb begin
        sum   = {1'b0, acc} + (ACC_W + 1)'(in_product);
        ovf_n = ovf | sum[ACC_W];
        acc_n = ovf_n ? '1 : sum[ACC_W-1:0];
        close = in_last || cnt == 9'(LEN - 1);
    end

    // frame accumulation, close into the result registers, and hold until downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (state == ACCUM) begin
            if (in_valid) begin
                if (close) begin
                    out_sum   <= acc_n;
                    out_count <= cnt + 9'd1;
                    out_ovf   <= ovf_n;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    state     <= HOLD;
                end else begin
                    acc <= acc_n;
                    cnt <= cnt + 9'd1;
                    ovf <= ovf_n;
                end
            end
        end else if (out_ready) begin
            state <= ACCUM;
        end
    end
endmodule

// File: tb/tb_mult_accumulator.sv
// tb_mult_accumulator: scoreboard bench over default, saturating (ACC_W=20, LEN=17) and LEN=1 instances
module tb_mult_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [17:0] prod [3];
    logic        iv   [3];
    logic        il   [3];
    logic        ordy [3];

    logic        r0, r1, r2, v0, v1, v2, o0, o1, o2;
    logic [23:0] s0, s2;
    logic [19:0] s1;
    logic [8:0]  c0, c1, c2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {longint sum; int cnt; bit ovf;} exp_t;
    exp_t q0[$], q1[$], q2[$];

    mult_accumulator dut0 (
        .clk(clk), .rst(rst), .in_product(prod[0]), .in_valid(iv[0]), .in_last(il[0]),
        .in_ready(r0), .out_sum(s0), .out_count(c0), .out_ovf(o0), .out_valid(v0), .out_ready(ordy[0])
    );

    mult_accumulator #(.LEN(17), .ACC_W(20)) dut1 (
        .clk(clk), .rst(rst), .in_product(prod[1]), .in_valid(iv[1]), .in_last(il[1]),
        .in_ready(r1), .out_sum(s1), .out_count(c1), .out_ovf(o1), .out_valid(v1), .out_ready(ordy[1])
    );

    mult_accumulator #(.LEN(1)) dut2 (
        .clk(clk), .rst(rst), .in_product(prod[2]), .in_valid(iv[2]), .in_last(il[2]),
        .in_ready(r2), .out_sum(s2), .out_count(c2), .out_ovf(o2), .out_valid(v2), .out_ready(ordy[2])
    );

    function automatic logic rdy(int k);
        return k == 0 ? r0 : k == 1 ? r1 : r2;
    endfunction

    function automatic logic vld(int k);
        return k == 0 ? v0 : k == 1 ? v1 : v2;
    endfunction

    function automatic longint osum(int k);
        return k == 0 ? longint'(s0) : k == 1 ? longint'(s1) : longint'(s2);
    endfunction

    function automatic int ocnt(int k);
        return k == 0 ? int'(c0) : k == 1 ? int'(c1) : int'(c2);
    endfunction

    function automatic logic oovf(int k);
        return k == 0 ? o0 : k == 1 ? o1 : o2;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push(int k, longint s, int c, bit o);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        if (k == 0) q0.push_back(e);
        else if (k == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    // monitor: pop and compare whenever a result transfers
    task automatic mon(int k);
        exp_t e;
        int n;
        if (!(vld(k) && ordy[k])) return;
        n = k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
        if (n == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d unexpected result: got sum %0d, want none", k, osum(k));
            return;
        end
        if (k == 0) e = q0.pop_front();
        else if (k == 1) e = q1.pop_front();
        else e = q2.pop_front();
        chk($sformatf("dut%0d out_sum", k), osum(k), e.sum);
        chk($sformatf("dut%0d out_count", k), ocnt(k), e.cnt);
        chk($sformatf("dut%0d out_ovf", k), oovf(k), e.ovf);
    endtask

    always @(negedge clk) for (int k = 0; k < 3; k++) mon(k);

    task automatic beat(int k, int p, bit l);
        int t = 0;
        prod[k] = 18'(p);
        iv[k] = 1'b1;
        il[k] = l;
        do begin
            @(negedge clk);
            t++;
        end while (!rdy(k) && t < 50);
        if (!rdy(k)) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d beat timeout: got in_ready 0, want 1", k);
        end
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        il[k] = 1'b0;
    endtask

    task automatic idle(int k, int n);
        repeat (n) begin
            il[k] = ~il[k];
            @(posedge clk);
            #1;
        end
        il[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            prod[k] = '0;
            iv[k] = 1'b0;
            il[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", r0, 0);
        chk("reset out_valid", v0, 0);
        chk("reset out_sum", s0, 0);
        chk("reset out_count", c0, 0);
        chk("reset out_ovf", o0, 0);
        chk("reset dut1 in_ready", r1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", r0, 1);
        @(posedge clk);
        #1;

        push(0, 136, 16, 0);
        for (int i = 1; i <= 16; i++) beat(0, i, 1'b0);
        @(negedge clk);
        chk("full frame bubble in_ready", r0, 0);
        chk("full frame out_valid", v0, 1);
        @(negedge clk);
        chk("full frame in_ready back", r0, 1);
        chk("full frame out_valid drop", v0, 0);
        @(posedge clk);
        #1;

        ordy[0] = 1'b0;
        push(0, 65132, 3, 0);
        beat(0, 65025, 1'b0);
        beat(0, 100, 1'b0);
        beat(0, 7, 1'b1);
        prod[0] = 18'd999;
        iv[0] = 1'b1;
        il[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", i), v0, 1);
            chk($sformatf("hold%0d out_sum", i), s0, 65132);
            chk($sformatf("hold%0d out_count", i), c0, 3);
            chk($sformatf("hold%0d in_ready", i), r0, 0);
        end
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        il[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("in_ready while result transfers", r0, 0);
        @(negedge clk);
        chk("in_ready after transfer", r0, 1);
        chk("out_valid after transfer", v0, 0);
        chk("out_sum held after transfer", s0, 65132);
        @(posedge clk);
        #1;
        push(0, 4, 1, 0);
        beat(0, 4, 1'b1);

        push(0, 60, 3, 0);
        beat(0, 10, 1'b0);
        idle(0, $urandom_range(1, 3));
        beat(0, 20, 1'b0);
        idle(0, $urandom_range(1, 3));
        beat(0, 30, 1'b1);

        for (int i = 0; i < 5; i++) beat(0, 1000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready during rst", r0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid-frame rst out_valid", v0, 0);
        chk("mid-frame rst out_sum", s0, 0);
        chk("mid-frame rst out_count", c0, 0);
        chk("mid-frame rst out_ovf", o0, 0);
        chk("mid-frame rst in_ready", r0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(0, 32, 16, 0);
        for (int i = 0; i < 16; i++) beat(0, 2, 1'b0);

        beat(0, 9, 1'b1);
        ordy[0] = 1'b0;
        @(negedge clk);
        chk("hold before rst out_valid", v0, 1);
        chk("hold before rst out_sum", s0, 9);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst in hold out_valid", v0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ordy[0] = 1'b1;

        push(1, 1048575, 17, 1);
        for (int i = 0; i < 17; i++) beat(1, 65025, 1'b0);
        push(1, 5, 2, 0);
        beat(1, 2, 1'b0);
        beat(1, 3, 1'b1);

        push(2, 5, 1, 0);
        push(2, 6, 1, 0);
        push(2, 7, 1, 0);
        for (int i = 5; i <= 7; i++) begin
            beat(2, i, 1'b0);
            @(negedge clk);
            chk($sformatf("len1 beat%0d in_ready low", i), r2, 0);
            @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        chk("dut0 results outstanding", q0.size(), 0);
        chk("dut1 results outstanding", q1.size(), 0);
        chk("dut2 results outstanding", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
